// File: rtl/control_edicion_campos.sv
// Edit-mode controller for the RTC date/time field counters.
// Converts debounced button levels into single-cycle up/down strobes for the
// selected field, with auto-repeat on held buttons, an inactivity timeout and
// a request/acknowledge commit handshake towards the RTC write sequencer.
module control_edicion_campos #(
  parameter int NFIELDS  = 7,
  parameter int SELW     = 3,
  parameter int CW       = 26,
  parameter int HOLD_CYC = 25_000_000,
  parameter int REP_CYC  = 5_000_000,
  parameter int TOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_mode,
  input  logic               btn_next,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               wr_ack,
  output logic               edit_act,
  output logic [SELW-1:0]    field_sel,
  output logic [NFIELDS-1:0] field_en,
  output logic               up_o,
  output logic               down_o,
  output logic               wr_req,
  output logic               tout_o
);

  // Bit positions inside the packed button vectors.
  localparam int B_MODE = 3;
  localparam int B_NEXT = 2;
  localparam int B_UP   = 1;
  localparam int B_DOWN = 0;

  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]   REP_LAST  = CW'(REP_CYC - 1);
  localparam logic [CW-1:0]   TOUT_LAST = CW'(TOUT_CYC - 1);
  localparam logic [SELW-1:0] SEL_LAST  = SELW'(NFIELDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  state_t             r_state;
  logic [3:0]         r_btn;        // buttons sampled once
  logic [3:0]         r_btn_d;      // previous sample; also the level aligned with r_rise
  logic [3:0]         r_rise;       // registered rising-edge detect
  logic [CW-1:0]      r_rep_cnt;
  logic               r_repeating;  // first repeat already emitted: use REP_CYC spacing
  logic [CW-1:0]      r_tout_cnt;
  logic               r_edit_act;
  logic [SELW-1:0]    r_field_sel;
  logic [NFIELDS-1:0] r_field_en;
  logic               r_up;
  logic               r_down;
  logic               r_wr_req;
  logic               r_tout;

  logic               w_up_lvl;
  logic               w_dn_lvl;
  logic               w_single;
  logic               w_rep_hit;
  logic               w_rep_fire;
  logic               w_updn_rise;
  logic               w_edge_up;
  logic               w_edge_dn;
  logic [NFIELDS-1:0] w_onehot;

  // r_btn_d holds the level from the same sample that produced r_rise, so the
  // FSM sees an edge and its "held" levels consistently on the same cycle.
  assign w_up_lvl    = r_btn_d[B_UP];
  assign w_dn_lvl    = r_btn_d[B_DOWN];
  assign w_single    = w_up_lvl ^ w_dn_lvl;
  assign w_rep_hit   = (r_rep_cnt == (r_repeating ? REP_LAST : HOLD_LAST));
  assign w_rep_fire  = w_single & w_rep_hit;
  assign w_updn_rise = r_rise[B_UP] | r_rise[B_DOWN];
  assign w_edge_up   = r_rise[B_UP] & ~w_dn_lvl;
  assign w_edge_dn   = r_rise[B_DOWN] & ~w_up_lvl;
  assign w_onehot    = NFIELDS'(1) << r_field_sel;

  // Sample the buttons and register their rising edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn   <= '0;
      r_btn_d <= '0;
      r_rise  <= '0;
    end else begin
      // NOTE: non-blocking assignments let r_btn_d and r_rise see the old
      // r_btn value, which is exactly the one-cycle delay edge detection needs.
      r_btn   <= {btn_mode, btn_next, btn_up, btn_down};
      r_btn_d <= r_btn;
      r_rise  <= r_btn & ~r_btn_d;
    end
  end

  // Edit FSM with registered outputs, repeat and timeout counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rep_cnt   <= '0;
      r_repeating <= 1'b0;
      r_tout_cnt  <= '0;
      r_edit_act  <= 1'b0;
      r_field_sel <= '0;
      r_field_en  <= '0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_wr_req    <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are raised only by the branch
      // that fires them, which guarantees single-cycle pulses.
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_tout     <= 1'b0;
      r_field_en <= '0;
      case (r_state)
        ST_IDLE: begin
          r_edit_act  <= 1'b0;
          r_rep_cnt   <= '0;
          r_repeating <= 1'b0;
          if (r_rise[B_MODE]) begin
            r_state     <= ST_EDIT;
            r_edit_act  <= 1'b1;
            r_field_sel <= '0;
            r_tout_cnt  <= '0;
          end
        end
        ST_EDIT: begin
          if (r_rise[B_MODE]) begin
            r_state    <= ST_COMMIT;
            r_edit_act <= 1'b0;
            r_wr_req   <= 1'b1;
          end else if (r_rise[B_NEXT]) begin
            r_field_sel <= (r_field_sel == SEL_LAST) ? '0 : r_field_sel + SELW'(1);
            r_tout_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
          end else if (w_updn_rise) begin
            // Opposite button held (or both rising) suppresses the strobe.
            r_tout_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
            r_up        <= w_edge_up;
            r_down      <= w_edge_dn;
            r_field_en  <= (w_edge_up | w_edge_dn) ? w_onehot : '0;
          end else begin
            if (!w_single) begin
              r_rep_cnt   <= '0;
              r_repeating <= 1'b0;
            end else if (w_rep_hit) begin
              r_rep_cnt   <= '0;
              r_repeating <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + CW'(1);
            end
            if (w_rep_fire) begin
              r_up       <= w_up_lvl;
              r_down     <= w_dn_lvl;
              r_field_en <= w_onehot;
              r_tout_cnt <= '0;
            end else if (r_tout_cnt == TOUT_LAST) begin
              // Abort without writing the RTC; field counters keep their values.
              r_state    <= ST_IDLE;
              r_edit_act <= 1'b0;
              r_tout     <= 1'b1;
            end else begin
              r_tout_cnt <= r_tout_cnt + CW'(1);
            end
          end
        end
        ST_COMMIT: begin
          if (wr_ack) begin
            r_state  <= ST_IDLE;
            r_wr_req <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign edit_act  = r_edit_act;
  assign field_sel = r_field_sel;
  assign field_en  = r_field_en;
  assign up_o      = r_up;
  assign down_o    = r_down;
  assign wr_req    = r_wr_req;
  assign tout_o    = r_tout;

endmodule
